// File: rtl/round_win_pkg.sv
// round_win_pkg
// Shared definitions for the Simon "round won" animation sequencer:
//   - anim_state_t : sequencer states (IDLE, CHASE, FLASH_ON, FLASH_OFF)
//   - SND_OFF / SND_CHORD : silent and victory-chord tone selects
//   - LAMPS_OFF / LAMPS_ALL : lamp patterns for idle/off and flash-on
//   - lamp_tone() : one-hot lamp/tone pattern for a chase step index
package round_win_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHASE     = 2'd1,
    FLASH_ON  = 2'd2,
    FLASH_OFF = 2'd3
  } anim_state_t;

  localparam logic [3:0] SND_OFF   = 4'h0;
  localparam logic [3:0] SND_CHORD = 4'hF;
  localparam logic [3:0] LAMPS_OFF = 4'h0;
  localparam logic [3:0] LAMPS_ALL = 4'hF;

  // Lamp n and tone n share the same one-hot position, so one pattern
  // serves both the lamp bus and the sound select.
  function automatic logic [3:0] lamp_tone(input logic [1:0] step);
    logic [3:0] pattern;
    case (step)
      2'd0:    pattern = 4'b0001;
      2'd1:    pattern = 4'b0010;
      2'd2:    pattern = 4'b0100;
      2'd3:    pattern = 4'b1000;
      default: pattern = 4'b0001;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/anim_step_timer.sv
// anim_step_timer
// Down-counter that paces one animation step. It reloads to STEP_CYCLES-1
// on clear, decrements while enabled, and raises tick for the one cycle
// in which it sits at zero while enabled; on that edge it reloads, so
// consecutive enabled periods are each exactly STEP_CYCLES cycles long.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low
//   clear  - reload the counter (priority over enable)
//   enable - count this cycle
//   tick   - terminal count reached this cycle (combinational from count)
module anim_step_timer #(
  parameter int unsigned STEP_CYCLES = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(STEP_CYCLES) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 32'd1);

  logic [CW-1:0] count_r;

  // Step counter: reload on reset/clear/terminal count, else count down.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= RELOAD;
    end else if (clear) begin
      count_r <= RELOAD;
    end else if (enable) begin
      if (count_r == CW'(0)) begin
        count_r <= RELOAD;
      end else begin
        count_r <= count_r - CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = enable && (count_r == CW'(0));

endmodule

// File: rtl/round_win_animation.sv
// round_win_animation
// Output sequencer for the Simon "round won" animation. A pulse on next
// while idle starts a lamp chase (lamp1..lamp4, CHASE_LAPS times) followed
// by FLASH_COUNT all-on/all-off flash pairs, then the block returns to idle.
// Every step and flash half-period lasts STEP_CYCLES cycles.
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous, active-low; forces idle and dark/silent
//   next          - start request, honoured only in idle
//   sound[3:0]    - tone select: one-hot lamp tone, 4'hF chord, 4'h0 silent
//   light1..4     - lamp drives
module round_win_animation
  import round_win_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25,
  parameter int unsigned CHASE_LAPS  = 2,
  parameter int unsigned FLASH_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next,
  output logic [3:0] sound,
  output logic       light1,
  output logic       light2,
  output logic       light3,
  output logic       light4
);

  localparam int unsigned LW = $clog2(CHASE_LAPS) + 1;
  localparam int unsigned FW = $clog2(FLASH_COUNT) + 1;
  localparam logic [LW-1:0] LAP_LAST = LW'(CHASE_LAPS - 32'd1);
  // Guarded so FLASH_COUNT=0 does not produce a negative constant; the
  // flash states are unreachable in that configuration anyway.
  localparam int unsigned FLASH_LAST_I = (FLASH_COUNT > 32'd0) ? (FLASH_COUNT - 32'd1) : 32'd0;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_LAST_I);

  anim_state_t   state_r, state_s;
  logic [1:0]    step_r, step_s;
  logic [LW-1:0] lap_r, lap_s;
  logic [FW-1:0] flash_r, flash_s;
  logic          tick_s;
  logic [3:0]    lamps_s, sound_s;
  logic [3:0]    lamps_r, sound_r;

  // The timer free-runs through CHASE and FLASH; each phase is a whole
  // number of STEP_CYCLES periods so its tick lines up with every phase end.
  anim_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_r == IDLE),
    .enable(state_r != IDLE),
    .tick  (tick_s)
  );

  // Next-state and counter update logic.
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    lap_s   = lap_r;
    flash_s = flash_r;
    case (state_r)
      IDLE: begin
        if (next) begin
          state_s = CHASE;
          step_s  = 2'd0;
          lap_s   = LW'(0);
          flash_s = FW'(0);
        end else begin
          state_s = IDLE;
        end
      end
      CHASE: begin
        if (tick_s) begin
          if (step_r == 2'd3) begin
            step_s = 2'd0;
            if (lap_r == LAP_LAST) begin
              lap_s   = LW'(0);
              flash_s = FW'(0);
              if (FLASH_COUNT > 32'd0) begin
                state_s = FLASH_ON;
              end else begin
                state_s = IDLE;
              end
            end else begin
              lap_s = lap_r + LW'(1);
            end
          end else begin
            step_s = step_r + 2'd1;
          end
        end else begin
          state_s = CHASE;
        end
      end
      FLASH_ON: begin
        if (tick_s) begin
          state_s = FLASH_OFF;
        end else begin
          state_s = FLASH_ON;
        end
      end
      FLASH_OFF: begin
        if (tick_s) begin
          if (flash_r == FLASH_LAST) begin
            flash_s = FW'(0);
            state_s = IDLE;
          end else begin
            flash_s = flash_r + FW'(1);
            state_s = FLASH_ON;
          end
        end else begin
          state_s = FLASH_OFF;
        end
      end
      default: begin
        state_s = IDLE;
        step_s  = 2'd0;
        lap_s   = LW'(0);
        flash_s = FW'(0);
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs change on
  // the same edge as the state they represent.
  always_comb begin
    lamps_s = LAMPS_OFF;
    sound_s = SND_OFF;
    case (state_s)
      CHASE: begin
        lamps_s = lamp_tone(step_s);
        sound_s = lamp_tone(step_s);
      end
      FLASH_ON: begin
        lamps_s = LAMPS_ALL;
        sound_s = SND_CHORD;
      end
      IDLE, FLASH_OFF: begin
        lamps_s = LAMPS_OFF;
        sound_s = SND_OFF;
      end
      default: begin
        lamps_s = LAMPS_OFF;
        sound_s = SND_OFF;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      step_r  <= 2'd0;
      lap_r   <= LW'(0);
      flash_r <= FW'(0);
      lamps_r <= LAMPS_OFF;
      sound_r <= SND_OFF;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      lap_r   <= lap_s;
      flash_r <= flash_s;
      lamps_r <= lamps_s;
      sound_r <= sound_s;
    end
  end

  assign sound  = sound_r;
  assign light1 = lamps_r[0];
  assign light2 = lamps_r[1];
  assign light3 = lamps_r[2];
  assign light4 = lamps_r[3];

endmodule

// File: tb/tb_round_win_animation.sv
// tb_round_win_animation
// Directed bench for round_win_animation: a default-parameter instance
// (25/2/3) and a corner instance (1/1/0). Observed outputs are packed as
// {sound, light4, light3, light2, light1} and compared against values
// derived from elapsed cycles since the start edge.
module tb_round_win_animation;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, next;
  logic [3:0] sound;
  logic       light1, light2, light3, light4;

  logic       reset_c, next_c;
  logic [3:0] sound_c;
  logic       light1_c, light2_c, light3_c, light4_c;

  int n_checks = 0;
  int n_fail   = 0;

  round_win_animation u_dut (
    .clk   (clk),
    .reset (reset),
    .next  (next),
    .sound (sound),
    .light1(light1),
    .light2(light2),
    .light3(light3),
    .light4(light4)
  );

  round_win_animation #(
    .STEP_CYCLES(1),
    .CHASE_LAPS (1),
    .FLASH_COUNT(0)
  ) u_corner (
    .clk   (clk),
    .reset (reset_c),
    .next  (next_c),
    .sound (sound_c),
    .light1(light1_c),
    .light2(light2_c),
    .light3(light3_c),
    .light4(light4_c)
  );

  wire [7:0] obs_main   = {sound, light4, light3, light2, light1};
  wire [7:0] obs_corner = {sound_c, light4_c, light3_c, light2_c, light1_c};

  // Expected default-parameter output k edges after the start edge (k=0).
  function automatic logic [7:0] exp_default(input int k);
    logic [3:0] one;
    logic [3:0] lamp;
    int s;
    one = 4'b0001;
    if (k < 0) return 8'h00;
    if (k < 200) begin
      s = (k / 25) % 4;
      lamp = one << s;
      return {lamp, lamp};
    end
    if (k < 350) begin
      if ((((k - 200) / 25) % 2) == 0) return 8'hFF;
      return 8'h00;
    end
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_onehot();
    logic [7:0] ones;
    ones = 8'($countones({light4, light3, light2, light1}));
    check("chase_onehot", ones, 8'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] corner_exp [11];
    corner_exp = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h00, 8'h11, 8'h22,
                   8'h44, 8'h88, 8'h00, 8'h00};

    reset   = 1'b0;
    next    = 1'b1;
    reset_c = 1'b0;
    next_c  = 1'b0;

    // Reset held with next high: dark and silent throughout.
    repeat (3) begin
      cycle();
      check("reset_hold", obs_main, 8'h00);
    end
    reset = 1'b1;
    next  = 1'b0;
    repeat (4) begin
      cycle();
      check("idle_after_reset", obs_main, 8'h00);
    end

    // Basic run.
    next = 1'b1;
    cycle();
    next = 1'b0;
    check("basic_start", obs_main, 8'h11);
    for (int k = 1; k <= 360; k++) begin
      cycle();
      check("basic_run", obs_main, exp_default(k));
      if (k < 200) check_onehot();
    end

    // Retrigger mid-run is ignored; the run still ends at cycle 350.
    repeat (3) cycle();
    next = 1'b1;
    cycle();
    next = 1'b0;
    check("retrig_start", obs_main, 8'h11);
    for (int k = 1; k <= 360; k++) begin
      next = (k == 100) ? 1'b1 : 1'b0;
      cycle();
      check("retrig_run", obs_main, exp_default(k));
    end
    next = 1'b0;

    // Reset mid-run at cycle 120, then a clean restart.
    repeat (3) cycle();
    next = 1'b1;
    cycle();
    next = 1'b0;
    for (int k = 1; k <= 119; k++) begin
      cycle();
      check("pre_reset_run", obs_main, exp_default(k));
    end
    reset = 1'b0;
    cycle();
    check("reset_mid", obs_main, 8'h00);
    reset = 1'b1;
    repeat (3) begin
      cycle();
      check("idle_after_mid_reset", obs_main, 8'h00);
    end
    next = 1'b1;
    cycle();
    next = 1'b0;
    check("restart_start", obs_main, 8'h11);
    for (int k = 1; k <= 110; k++) begin
      cycle();
      check("restart_run", obs_main, exp_default(k));
    end

    // Corner: 1-cycle steps, one lap, no flashes, next held high.
    reset_c = 1'b1;
    next_c  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 6) next_c = 1'b0;
      cycle();
      check("corner_seq", obs_corner, corner_exp[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_win_animation.md
Name: round_win_animation

Overview:
- Plays the Simon "round won" light/sound animation when the game controller pulses `next`.
- The animation is a lamp chase, lamp1 to lamp4, repeated for a number of laps, followed by all-lamp flashes. The block then returns to idle.
- Sits between the game FSM (which issues `next`) and the lamp/tone drivers. It is purely an output sequencer and has no completion port.

Parameters:
- STEP_CYCLES, 25, clock cycles per chase step and per flash half-period (must be ≥1).
- CHASE_LAPS, 2, number of full 1→2→3→4 chase passes (must be ≥1).
- FLASH_COUNT, 3, number of all-on/all-off flash pairs after the chase (≥0; 0 skips flashing).

Ports:
- clk, input, 1, single system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- next, input, 1, start request, sampled each rising edge.
- sound, output, 4, tone select: one-hot per lamp tone, 4'hF = victory chord, 4'h0 = silent.
- light1, output, 1, lamp 1 drive.
- light2, output, 1, lamp 2 drive.
- light3, output, 1, lamp 3 drive.
- light4, output, 1, lamp 4 drive.

Behaviour:
- All outputs are registered.
- Reset: when reset==0 at a rising edge, the block goes to IDLE, clears all counters, and sets sound=0 and light1..4=0 from that edge. Reset takes priority over `next` and applies mid-animation.
- States: IDLE, CHASE, FLASH_ON, FLASH_OFF.
- IDLE:
  - Outputs are all 0.
  - If next==1 at an edge, go to CHASE with lap=0, step=0, timer=0.
  - light1=1 and sound=4'b0001 are visible immediately after that same edge (one-edge latency).
- CHASE:
  - Lamp index `step` (0..3) is lit alone and sound=1<<step.
  - The timer counts 0..STEP_CYCLES-1. At terminal count it resets and step increments.
  - When step wraps from 3 to 0, lap increments.
  - After the final step of lap CHASE_LAPS-1: go to FLASH_ON if FLASH_COUNT>0, else IDLE.
- FLASH_ON: all four lamps lit, sound=4'hF, for STEP_CYCLES cycles, then go to FLASH_OFF.
- FLASH_OFF:
  - All lamps off, sound=0, for STEP_CYCLES cycles.
  - Then the flash counter increments. If the count equals FLASH_COUNT, go to IDLE; else go to FLASH_ON.
- Total busy duration: (4·CHASE_LAPS + 2·FLASH_COUNT)·STEP_CYCLES cycles. The default is 350 cycles.
- Retriggering:
  - `next` is ignored while not in IDLE; there is no restart and no queuing.
  - `next` held high continuously re-arms only on the edge at which IDLE is re-entered.
  - Such a restart begins on the following edge, because IDLE is observed for at least one cycle.
- Exactly one lamp is lit during CHASE. No lamp is lit in IDLE or FLASH_OFF.
- Counter widths: $clog2 of their maximum + 1. No overflow is possible within legal parameters.

Decomposition:
- Package round_win_pkg:
  - state enum (IDLE, CHASE, FLASH_ON, FLASH_OFF);
  - sound constants SND_OFF=4'h0, SND_CHORD=4'hF;
  - lamp-tone one-hot helper function.
- One sub-module, anim_step_timer: parameterised down-counter with clear input, enable input and a one-cycle `tick` at terminal count. It is reused for the chase-step and flash timing.
- Top level holds the FSM, lap/step/flash counters and the output registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles with next=1 → all outputs 0 throughout; the block stays IDLE after reset=1 until next is sampled.
- Basic run (defaults): pulse next for 1 cycle → light1 and sound=4'b0001 on the next edge.
  - After 25 cycles, light2 and 4'b0010; then light3 and 4'b0100; then light4 and 4'b1000.
  - The chase repeats for 2 laps (200 cycles).
  - Then 3×(25 cycles all lamps on, sound=4'hF; 25 cycles off, sound=0).
  - Outputs stay 0 after 350 cycles.
- One-hot check: during CHASE, exactly one of light1..4 is high and sound equals the one-hot of that lamp on every cycle.
- Retrigger ignore: pulse next at cycle 100 of a run → the sequence and total duration are unchanged (ends at cycle 350).
- Reset mid-run: drive reset=0 at cycle 120 → all outputs 0 on that edge. A new next then restarts from light1, lap 0.
- Parameter corner: STEP_CYCLES=1, CHASE_LAPS=1, FLASH_COUNT=0 → lights 1,2,3,4 on four consecutive cycles, then IDLE; next held high restarts after one idle cycle.
